salamander_capture_ctrl: RTL and testbench
==========================================

# salamander_capture_ctrl

Synthesizable sequencer that controls the Salamander video-capture datapath. It watches the 6 MHz-enabled H/V counters and schedules which frames, lines and pixels the frame writer stores. It also generates the bottom-up BMP line file offsets, applies frame decimation and N-frame capture runs, and flags writer overruns. It sits between the video timing generator and the capture writer/file sink.

## Interface
- No parameters. The geometry is fixed: 224 lines × 256 pixels, BMP 24 bpp, 54-byte header.
- i_EMU_MCLK  in  1  master clock; all logic on its rising edge.
- i_EMU_RST  in  1  synchronous, active-high reset.
- i_EMU_CLK6MPCEN_n  in  1  pixel clock enable, active low. Counters are sampled only when it is 0.
- i_HCOUNTER  in  9  horizontal counter.
- i_VCOUNTER  in  9  vertical counter.
- i_ARM  in  1  one-cycle start request; honoured only in IDLE.
- i_ABORT  in  1  one-cycle stop request; honoured in any non-IDLE state.
- i_FRAME_COUNT  in  8  number of frames to capture; 0 means no-op. Sampled on an accepted i_ARM.
- i_SKIP  in  4  frames skipped between captured frames. Sampled on an accepted i_ARM.
- i_SINK_READY  in  1  writer can accept a pixel this cycle.
- o_BUSY  out  1  high from accepted arm until DONE or abort.
- o_DONE  out  1  one-cycle pulse after the last frame_end, or after an arm with count 0.
- o_FRAME_START  out  1  one-cycle pulse: open a new frame file.
- o_LINE_START  out  1  one-cycle pulse: seek to o_LINE_ADDR.
- o_LINE_ADDR  out  20  byte offset of the current line in the BMP.
- o_PIXEL_VALID  out  1  one-cycle pulse per captured pixel.
- o_PIX_X  out  8  pixel index within the line, 0..255.
- o_LINE_END  out  1  one-cycle pulse after the last pixel of a line.
- o_FRAME_END  out  1  one-cycle pulse: close the frame file.
- o_FRAME_NUM  out  16  index of the current or last captured frame.
- o_OVERRUN  out  1  sticky flag; cleared on an accepted arm.

## Operation
- Qualified event: any condition below counts only in an i_EMU_CLK6MPCEN_n=0 cycle.
- Event definitions:
  - FB (frame boundary): V==272 && H==276.
  - LS (line start): V in 272..495 && H==277.
  - PX (pixel): H>277 || H<150.
  - LE (line end): H==150.
  - FE (frame end): V==495 && H==151.
- FSM states: IDLE, WAIT, SKIP, CAPTURE.
- IDLE:
  - Accepted i_ARM with count≠0: load remaining=i_FRAME_COUNT, phase=0, clear o_OVERRUN, go to WAIT.
  - Accepted i_ARM with count=0: pulse o_DONE and stay in IDLE.
- WAIT/SKIP, on FB:
  - If phase==0: go to CAPTURE, pulse o_FRAME_START, set o_LINE_ADDR=0x29D36, set phase=i_SKIP.
  - Otherwise: phase−1, go to SKIP.
- SKIP returns to WAIT on FE.
- CAPTURE:
  - LS: pulse o_LINE_START, set in_line=1, o_PIX_X=0.
  - PX while in_line: pulse o_PIXEL_VALID with the current o_PIX_X, then o_PIX_X+1 (8-bit, wraps to 0 after 255).
  - LE while in_line: pulse o_LINE_END, clear in_line, o_LINE_ADDR −= 0x300 (modulo 2^20).
  - PX or LE with in_line=0 (e.g. V=272, H<150 before the first LS): ignored.
  - FE: pulse o_FRAME_END, o_FRAME_NUM+1 (16-bit wrap), remaining−1.
    - If remaining becomes 0: pulse o_DONE and go to IDLE.
    - Otherwise: go to WAIT.
- Line address: line n (n=V−272) has offset 0x36+(223−n)·0x300, so the last line is at 0x36.
- Overrun: o_PIXEL_VALID asserted while i_SINK_READY=0 sets o_OVERRUN. The capture continues; video is never stalled.
- Abort: go to IDLE the next cycle. No o_FRAME_END and no o_DONE are pulsed, and in_line is cleared. o_FRAME_NUM and o_OVERRUN are kept.
- Simultaneous i_ARM and i_ABORT in IDLE: the arm wins. In any other state: the abort wins and the arm is ignored.

## Timing
- Every output is a register. A strobe appears one MCLK after the qualified cycle that produced it and lasts exactly one MCLK.
- o_LINE_ADDR is valid in the same cycle as o_LINE_START. o_PIX_X is valid with o_PIXEL_VALID.
- Reset, including mid-capture: state=IDLE, all strobes 0, o_BUSY=0, o_LINE_ADDR=0, o_PIX_X=0, o_FRAME_NUM=0, o_OVERRUN=0, remaining=0, phase=0.
- o_BUSY rises the cycle after an accepted arm. It falls in the same cycle as o_DONE, or the cycle after an abort.
- A frame yields exactly 224 LINE_START pulses, 224 LINE_END pulses and 57,344 PIXEL_VALID pulses (256 per line).

## Test plan
- Arm with count=1, skip=0, then run one full frame → 1 FRAME_START; LINE_ADDR 0x29D36 on the first LS and 0x36 on the last; 57,344 pixels; FRAME_END; DONE; FRAME_NUM=1.
- Arm with count=3, skip=2 across 9 frames → frames 0, 3 and 6 after the arm are captured, 3 FRAME_ENDs, DONE after the 7th FE, BUSY low afterwards.
- Arm with count=0 → DONE one cycle later; BUSY never asserts; no FRAME_START.
- Hold i_SINK_READY=0 for one pixel mid-line → o_OVERRUN=1 and stays 1 through DONE; a new arm clears it.
- Assert i_ABORT at V=300, H=400 → IDLE next cycle; no further strobes, FRAME_END or DONE; FRAME_NUM unchanged.
- Assert i_EMU_RST mid-line → all outputs at their reset values the next cycle; a later FB without an arm produces no FRAME_START.

Source files
------------

// File: rtl/salamander_capture_ctrl.sv
// rtl/salamander_capture_ctrl.sv - capture sequencer for the Salamander video datapath
module salamander_capture_ctrl (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_RST,
  input  logic        i_EMU_CLK6MPCEN_n,
  input  logic [8:0]  i_HCOUNTER,
  input  logic [8:0]  i_VCOUNTER,
  input  logic        i_ARM,
  input  logic        i_ABORT,
  input  logic [7:0]  i_FRAME_COUNT,
  input  logic [3:0]  i_SKIP,
  input  logic        i_SINK_READY,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_FRAME_START,
  output logic        o_LINE_START,
  output logic [19:0] o_LINE_ADDR,
  output logic        o_PIXEL_VALID,
  output logic [7:0]  o_PIX_X,
  output logic        o_LINE_END,
  output logic        o_FRAME_END,
  output logic [15:0] o_FRAME_NUM,
  output logic        o_OVERRUN
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SKIP,
    ST_CAPTURE
  } state_t;

  state_t     state;
  logic [7:0] remaining;
  logic [3:0] phase;
  logic [3:0] skip_cfg;
  logic [7:0] pix_cnt;
  logic       in_line;

  logic pce;
  logic ev_fb, ev_ls, ev_px, ev_le, ev_fe;

  // Counter decodes only count on pixel-enable cycles.
  assign pce   = ~i_EMU_CLK6MPCEN_n;
  assign ev_fb = pce && (i_VCOUNTER == 9'd272) && (i_HCOUNTER == 9'd276);
  assign ev_ls = pce && (i_VCOUNTER >= 9'd272) && (i_VCOUNTER <= 9'd495) && (i_HCOUNTER == 9'd277);
  assign ev_px = pce && ((i_HCOUNTER > 9'd277) || (i_HCOUNTER < 9'd150));
  assign ev_le = pce && (i_HCOUNTER == 9'd150);
  assign ev_fe = pce && (i_VCOUNTER == 9'd495) && (i_HCOUNTER == 9'd151);

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      state         <= ST_IDLE;
      remaining     <= 8'd0;
      phase         <= 4'd0;
      skip_cfg      <= 4'd0;
      pix_cnt       <= 8'd0;
      in_line       <= 1'b0;
      o_BUSY        <= 1'b0;
      o_DONE        <= 1'b0;
      o_FRAME_START <= 1'b0;
      o_LINE_START  <= 1'b0;
      o_LINE_ADDR   <= 20'd0;
      o_PIXEL_VALID <= 1'b0;
      o_PIX_X       <= 8'd0;
      o_LINE_END    <= 1'b0;
      o_FRAME_END   <= 1'b0;
      o_FRAME_NUM   <= 16'd0;
      o_OVERRUN     <= 1'b0;
    end else begin
      o_DONE        <= 1'b0;
      o_FRAME_START <= 1'b0;
      o_LINE_START  <= 1'b0;
      o_PIXEL_VALID <= 1'b0;
      o_LINE_END    <= 1'b0;
      o_FRAME_END   <= 1'b0;

      // The writer cannot stall video, so a refused pixel is only recorded.
      if (o_PIXEL_VALID && !i_SINK_READY)
        o_OVERRUN <= 1'b1;

      if (state == ST_IDLE) begin
        if (i_ARM) begin
          o_OVERRUN <= 1'b0;
          if (i_FRAME_COUNT == 8'd0) begin
            o_DONE <= 1'b1;
          end else begin
            remaining <= i_FRAME_COUNT;
            phase     <= 4'd0;
            skip_cfg  <= i_SKIP;
            o_BUSY    <= 1'b1;
            state     <= ST_WAIT;
          end
        end
      end else if (i_ABORT) begin
        state   <= ST_IDLE;
        o_BUSY  <= 1'b0;
        in_line <= 1'b0;
      end else begin
        case (state)
          ST_WAIT, ST_SKIP: begin
            if (ev_fb) begin
              if (phase == 4'd0) begin
                state         <= ST_CAPTURE;
                o_FRAME_START <= 1'b1;
                o_LINE_ADDR   <= 20'h29D36;
                phase         <= skip_cfg;
              end else begin
                phase <= phase - 4'd1;
                state <= ST_SKIP;
              end
            end else if (state == ST_SKIP && ev_fe) begin
              state <= ST_WAIT;
            end
          end
          ST_CAPTURE: begin
            if (ev_ls) begin
              o_LINE_START <= 1'b1;
              in_line      <= 1'b1;
              o_PIX_X      <= 8'd0;
              pix_cnt      <= 8'd0;
            end else if (ev_px && in_line) begin
              o_PIXEL_VALID <= 1'b1;
              o_PIX_X       <= pix_cnt;
              pix_cnt       <= pix_cnt + 8'd1;
            end else if (ev_le && in_line) begin
              o_LINE_END  <= 1'b1;
              in_line     <= 1'b0;
              // BMP rows are stored bottom-up, so each new line sits one row lower in the file.
              o_LINE_ADDR <= o_LINE_ADDR - 20'h300;
            end else if (ev_fe) begin
              o_FRAME_END <= 1'b1;
              o_FRAME_NUM <= o_FRAME_NUM + 16'd1;
              remaining   <= remaining - 8'd1;
              if (remaining == 8'd1) begin
                o_DONE <= 1'b1;
                o_BUSY <= 1'b0;
                state  <= ST_IDLE;
              end else begin
                state <= ST_WAIT;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_salamander_capture_ctrl.sv
// tb/tb_salamander_capture_ctrl.sv - scoreboard bench for salamander_capture_ctrl
module tb_salamander_capture_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cen_n, arm, abort, ready;
  logic [8:0]  hc, vc;
  logic [7:0]  fcnt;
  logic [3:0]  skp;
  logic        o_busy, o_done, o_fs, o_ls, o_px, o_le, o_fe, o_ovr;
  logic [19:0] o_addr;
  logic [7:0]  o_pix;
  logic [15:0] o_fnum;

  salamander_capture_ctrl dut (
    .i_EMU_MCLK(clk), .i_EMU_RST(rst), .i_EMU_CLK6MPCEN_n(cen_n),
    .i_HCOUNTER(hc), .i_VCOUNTER(vc), .i_ARM(arm), .i_ABORT(abort),
    .i_FRAME_COUNT(fcnt), .i_SKIP(skp), .i_SINK_READY(ready),
    .o_BUSY(o_busy), .o_DONE(o_done), .o_FRAME_START(o_fs), .o_LINE_START(o_ls),
    .o_LINE_ADDR(o_addr), .o_PIXEL_VALID(o_px), .o_PIX_X(o_pix), .o_LINE_END(o_le),
    .o_FRAME_END(o_fe), .o_FRAME_NUM(o_fnum), .o_OVERRUN(o_ovr)
  );

  localparam logic [5:0] M_FS = 6'b100000, M_LS = 6'b010000, M_PX = 6'b001000;
  localparam logic [5:0] M_LE = 6'b000100, M_FE = 6'b000010, M_DN = 6'b000001;

  typedef struct {
    int          cyc;
    logic [5:0]  stb;
    logic [19:0] addr;
    logic [7:0]  pix;
    logic [15:0] fnum;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  int   n_fs = 0, n_ls = 0, n_le = 0, n_px = 0, n_fe = 0, n_dn = 0;

  // Reference model state.
  bit m_busy, m_cap, m_inl, m_ovr, m_pix_out;
  int m_left, m_skip, m_fbs, m_pix, m_fnum;

  // Per-step request knobs, consumed by step().
  bit t_arm, t_abort, t_rst;
  bit t_ready = 1'b1;
  int t_cnt, t_skip;
  bit drop_once, rnd_ready;
  int abort_cd = 0;
  int gap_div = 4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [5:0] stb, input int addr, input int pix);
    exp_t e;
    e.cyc  = cyc + 1;
    e.stb  = stb;
    e.addr = addr[19:0];
    e.pix  = pix[7:0];
    e.fnum = m_fnum[15:0];
    e.busy = m_busy;
    exp_q.push_back(e);
  endtask

  task automatic model(input bit q, input int v, input int h);
    bit fb, ls, px, le, fe, pix_now;
    fb = q && v == 272 && h == 276;
    ls = q && v >= 272 && v <= 495 && h == 277;
    px = q && (h > 277 || h < 150);
    le = q && h == 150;
    fe = q && v == 495 && h == 151;
    pix_now = 1'b0;
    if (t_rst) begin
      m_busy = 0; m_cap = 0; m_inl = 0; m_ovr = 0; m_pix_out = 0;
      m_left = 0; m_fnum = 0; m_pix = 0;
      return;
    end
    if (m_pix_out && !t_ready) m_ovr = 1;
    if (!m_busy) begin
      if (t_arm) begin
        m_ovr = 0;
        if (t_cnt == 0) push(M_DN, 0, 0);
        else begin
          m_busy = 1; m_left = t_cnt; m_skip = t_skip; m_fbs = 0; m_cap = 0;
        end
      end
    end else if (t_abort) begin
      m_busy = 0; m_cap = 0; m_inl = 0;
    end else if (!m_cap) begin
      // Every (skip+1)-th frame boundary after the arm is captured.
      if (fb) begin
        if (m_fbs % (m_skip + 1) == 0) begin
          m_cap = 1;
          push(M_FS, 0, 0);
        end
        m_fbs++;
      end
    end else if (ls) begin
      m_inl = 1; m_pix = 0;
      push(M_LS, 'h36 + (223 - (v - 272)) * 'h300, 0);
    end else if (px && m_inl) begin
      push(M_PX, 0, m_pix);
      m_pix = (m_pix + 1) % 256;
      pix_now = 1'b1;
    end else if (le && m_inl) begin
      m_inl = 0;
      push(M_LE, 0, 0);
    end else if (fe) begin
      m_fnum = (m_fnum + 1) % 65536;
      m_left--;
      m_cap = 0;
      if (m_left == 0) begin
        m_busy = 0;
        push(M_FE | M_DN, 0, 0);
      end else push(M_FE, 0, 0);
    end
    m_pix_out = pix_now;
  endtask

  task automatic step(input bit c_n, input int v, input int h);
    @(posedge clk);
    #1;
    if (drop_once && m_pix_out) begin
      t_ready = 1'b0;
      drop_once = 1'b0;
    end
    if (rnd_ready && $urandom_range(0, 15) == 0) t_ready = 1'b0;
    if (abort_cd > 0) begin
      abort_cd--;
      if (abort_cd == 0) t_abort = 1'b1;
    end
    rst = t_rst; cen_n = c_n; vc = v[8:0]; hc = h[8:0];
    arm = t_arm; abort = t_abort; ready = t_ready;
    fcnt = t_cnt[7:0]; skp = t_skip[3:0];
    model(!c_n, v, h);
    t_arm = 0; t_abort = 0; t_rst = 0; t_ready = 1'b1;
  endtask

  // Qualified tick, sometimes preceded by disabled cycles carrying event-like counter values.
  task automatic qtick(input int v, input int h);
    int tv[5] = '{272, 495, 300, 300, 300};
    int th[5] = '{276, 151, 277, 300, 150};
    if ($urandom_range(0, gap_div - 1) == 0) begin
      for (int g = 0; g < $urandom_range(1, 2); g++) begin
        int k = $urandom_range(0, 4);
        step(1'b1, tv[k], th[k]);
      end
    end
    step(1'b0, v, h);
  endtask

  task automatic line(input int v, input int npix, input bit full);
    qtick(v, 277);
    if (full) begin
      for (int h = 278; h <= 511; h++) qtick(v, h);
      for (int h = 128; h <= 149; h++) qtick(v, h);
    end else begin
      for (int i = 0; i < npix; i++) qtick(v, 278 + i);
    end
    qtick(v, 150);
  endtask

  task automatic frame(input int nlines, input int npix, input bit full);
    qtick(272, 276);
    qtick(272, 130);
    qtick(272, 150);
    for (int i = 0; i < nlines; i++) line(272 + i, npix, full);
    qtick(495, 151);
    qtick(495, 277);
  endtask

  task automatic checkpoint(input string name);
    step(1'b1, 0, 0);
    @(negedge clk);
    #1;
    chk({name, "_busy"}, {31'd0, o_busy}, {31'd0, m_busy});
    chk({name, "_overrun"}, {31'd0, o_ovr}, {31'd0, m_ovr});
    chk({name, "_frame_num"}, {16'd0, o_fnum}, m_fnum);
  endtask

  task automatic reset_check(input string name);
    step(1'b1, 0, 0);
    @(negedge clk);
    #1;
    chk({name, "_strobes"}, {26'd0, o_fs, o_ls, o_px, o_le, o_fe, o_done}, 32'd0);
    chk({name, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({name, "_addr"}, {12'd0, o_addr}, 32'd0);
    chk({name, "_pix_x"}, {24'd0, o_pix}, 32'd0);
    chk({name, "_frame_num"}, {16'd0, o_fnum}, 32'd0);
    chk({name, "_overrun"}, {31'd0, o_ovr}, 32'd0);
  endtask

  always @(negedge clk) begin
    logic [5:0] stb;
    exp_t e;
    stb = {o_fs, o_ls, o_px, o_le, o_fe, o_done};
    if (stb != 6'd0 && !$isunknown(stb)) begin
      n_fs += int'(o_fs); n_ls += int'(o_ls); n_px += int'(o_px);
      n_le += int'(o_le); n_fe += int'(o_fe); n_dn += int'(o_done);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_strobe: cycle %0d strobes %b, none expected", cyc, stb);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.stb != stb || e.busy != o_busy || e.fnum != o_fnum ||
            (e.stb[4] && e.addr != o_addr) || (e.stb[3] && e.pix != o_pix)) begin
          n_bad++;
          $display("FAIL strobe_record: got cyc=%0d stb=%b busy=%b fnum=%0d addr=%h pix=%0d expected cyc=%0d stb=%b busy=%b fnum=%0d addr=%h pix=%0d",
                   cyc, stb, o_busy, o_fnum, o_addr, o_pix,
                   e.cyc, e.stb, e.busy, e.fnum, e.addr, e.pix);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs0, fe0, dn0, ls0, le0, px0, fnum_saved;
    rst = 1'b1; cen_n = 1'b1; hc = 9'd0; vc = 9'd0; arm = 1'b0; abort = 1'b0;
    fcnt = 8'd0; skp = 4'd0; ready = 1'b1;

    t_rst = 1'b1; step(1'b1, 0, 0);
    reset_check("reset");

    // Single full frame.
    gap_div = 64;
    t_arm = 1'b1; t_cnt = 1; t_skip = 0; step(1'b1, 0, 0);
    fs0 = n_fs; ls0 = n_ls; le0 = n_le; px0 = n_px; fe0 = n_fe; dn0 = n_dn;
    frame(224, 0, 1'b1);
    checkpoint("full");
    chk("full_frame_starts", n_fs - fs0, 1);
    chk("full_line_starts", n_ls - ls0, 224);
    chk("full_line_ends", n_le - le0, 224);
    chk("full_pixels", n_px - px0, 57344);
    chk("full_frame_ends", n_fe - fe0, 1);
    chk("full_done", n_dn - dn0, 1);
    chk("full_frame_num", {16'd0, o_fnum}, 1);
    gap_div = 4;

    // Decimated run: count 3, skip 2, across nine frames.
    t_arm = 1'b1; t_cnt = 3; t_skip = 2; step(1'b1, 0, 0);
    fs0 = n_fs; fe0 = n_fe; dn0 = n_dn;
    for (int f = 0; f < 9; f++) frame(2, 3, 1'b0);
    checkpoint("skip");
    chk("skip_frame_starts", n_fs - fs0, 3);
    chk("skip_frame_ends", n_fe - fe0, 3);
    chk("skip_done", n_dn - dn0, 1);
    chk("skip_busy_low", {31'd0, o_busy}, 0);

    // Zero-count arm.
    fs0 = n_fs; dn0 = n_dn;
    t_arm = 1'b1; t_cnt = 0; t_skip = 0; step(1'b1, 0, 0);
    checkpoint("zero");
    chk("zero_done", n_dn - dn0, 1);
    chk("zero_no_frame_start", n_fs - fs0, 0);

    // One refused pixel sets the sticky overrun flag.
    t_arm = 1'b1; t_cnt = 1; t_skip = 0; step(1'b1, 0, 0);
    drop_once = 1'b1;
    frame(2, 4, 1'b0);
    checkpoint("ovr");
    chk("ovr_sticky", {31'd0, o_ovr}, 1);
    t_arm = 1'b1; t_cnt = 0; step(1'b1, 0, 0);
    checkpoint("ovr_clear");
    chk("ovr_cleared", {31'd0, o_ovr}, 0);

    // Abort mid-line at V=300, H=400.
    t_arm = 1'b1; t_cnt = 2; t_skip = 0; step(1'b1, 0, 0);
    qtick(272, 276);
    for (int v = 272; v < 300; v++) line(v, 2, 1'b0);
    qtick(300, 277);
    for (int h = 278; h < 400; h++) qtick(300, h);
    fnum_saved = m_fnum;
    t_abort = 1'b1; step(1'b0, 300, 400);
    fe0 = n_fe; dn0 = n_dn; fs0 = n_fs;
    for (int v = 301; v <= 495; v++) line(v, 1, 1'b0);
    qtick(495, 151);
    frame(2, 2, 1'b0);
    checkpoint("abort");
    chk("abort_no_frame_end", n_fe - fe0, 0);
    chk("abort_no_done", n_dn - dn0, 0);
    chk("abort_no_frame_start", n_fs - fs0, 0);
    chk("abort_frame_num", {16'd0, o_fnum}, fnum_saved);

    // Reset mid-line, then an unarmed frame.
    t_arm = 1'b1; t_cnt = 1; t_skip = 0; step(1'b1, 0, 0);
    qtick(272, 276);
    qtick(272, 277);
    for (int h = 278; h < 291; h++) qtick(272, h);
    t_rst = 1'b1; step(1'b0, 272, 291);
    reset_check("midreset");
    fs0 = n_fs;
    frame(2, 3, 1'b0);
    chk("midreset_no_frame_start", n_fs - fs0, 0);

    // Randomised runs with sink drops and occasional aborts.
    rnd_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int nf;
      t_arm = 1'b1; t_cnt = $urandom_range(0, 3); t_skip = $urandom_range(0, 3);
      nf = t_cnt * (t_skip + 1) + 1;
      if (nf > 8) nf = 8;
      abort_cd = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 60) : 0;
      step(1'b1, 0, 0);
      for (int f = 0; f < nf; f++) frame($urandom_range(1, 3), $urandom_range(1, 6), 1'b0);
      abort_cd = 0;
      checkpoint("random");
    end
    rnd_ready = 1'b0;

    for (int i = 0; i < 4; i++) step(1'b1, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
